// File: rtl/msft_dv_debug_apb_master.sv
// Debug-path APB4 requester: turns single-beat valid/ready requests into
// APB setup/access transfers and returns data, error and timeout status.
module msft_dv_debug_apb_master #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                        clk_i,
   input  logic                        rstn_i,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic [APB_ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [APB_DATA_WIDTH-1:0]   req_wdata_i,
   input  logic                        req_write_i,
   input  logic [APB_DATA_WIDTH/8-1:0] req_strb_i,
   output logic                        rsp_valid_o,
   input  logic                        rsp_ready_i,
   output logic [APB_DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                        rsp_err_o,
   output logic                        rsp_timeout_o,
   output logic                        psel_o,
   output logic                        penable_o,
   output logic                        pwrite_o,
   output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
   output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
   output logic [APB_DATA_WIDTH/8-1:0] pstrb_o,
   input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
   input  logic                        pready_i,
   input  logic                        pslverr_i,
   output logic                        busy_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             complete;
   logic             abort;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      req_ready_o = 1'b0;
      psel_o      = 1'b0;
      penable_o   = 1'b0;
      rsp_valid_o = 1'b0;
      busy_o      = 1'b1;
      accept      = 1'b0;
      complete    = 1'b0;
      abort       = 1'b0;
      case (state)
         IDLE: begin
            req_ready_o = 1'b1;
            busy_o      = 1'b0;
            accept      = req_valid_i;
            if (req_valid_i) state_nxt = SETUP;
         end
         SETUP: begin
            psel_o    = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            psel_o    = 1'b1;
            penable_o = 1'b1;
            complete  = pready_i;
            // Checked before the increment so the abort lands on the
            // TIMEOUT_CYCLES-th ACCESS cycle.
            abort     = !pready_i && (cnt == CNT_LAST);
            if (pready_i || abort) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Payload holds from accept until the next accept.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         paddr_o  <= '0;
         pwdata_o <= '0;
         pwrite_o <= 1'b0;
         pstrb_o  <= '0;
      end else if (accept) begin
         paddr_o  <= req_addr_i;
         pwdata_o <= req_wdata_i;
         pwrite_o <= req_write_i;
         pstrb_o  <= req_write_i ? req_strb_i : '0;
      end
   end

   // Saturating wait-state counter, cleared in SETUP.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt <= '0;
      end else if (state == SETUP) begin
         cnt <= '0;
      end else if (state == ACCESS && !pready_i && cnt != '1) begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rsp_rdata_o   <= '0;
         rsp_err_o     <= 1'b0;
         rsp_timeout_o <= 1'b0;
      end else if (complete) begin
         rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
         rsp_err_o     <= pslverr_i;
         rsp_timeout_o <= 1'b0;
      end else if (abort) begin
         rsp_rdata_o   <= '0;
         rsp_err_o     <= 1'b1;
         rsp_timeout_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_msft_dv_debug_apb_master.sv
// Directed bench for msft_dv_debug_apb_master with a configurable APB slave.
module tb_msft_dv_debug_apb_master;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_strb;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite, pready, pslverr, busy;
   logic [31:0] paddr, pwdata, prdata;
   logic [3:0]  pstrb;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // slave configuration
   int          slv_wait = 0;
   logic        slv_hang = 1'b0;
   logic        slv_err  = 1'b0;
   logic [31:0] slv_rdata = '0;
   int          acc_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign pready  = psel && penable && !slv_hang && (acc_cnt == slv_wait);
   assign pslverr = slv_err;
   assign prdata  = slv_rdata;

   always @(posedge clk) begin
      if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
      else                            acc_cnt <= 0;
   end

   msft_dv_debug_apb_master #(
      .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk_i(clk), .rstn_i(rstn),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .req_write_i(req_write), .req_strb_i(req_strb),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
      .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
      .paddr_o(paddr), .pwdata_o(pwdata), .pstrb_o(pstrb),
      .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr),
      .busy_o(busy)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          wt;
      logic        hang;
      logic        serr;
      logic [31:0] srdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_to;
      int          exp_acc;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Runs one transfer; starts and ends at a negedge with the DUT in IDLE.
   task automatic do_xfer(input int idx, input vec_t v);
      int          n;
      logic        stable;
      logic [31:0] a0, d0;
      slv_wait  = v.wt;
      slv_hang  = v.hang;
      slv_err   = v.serr;
      slv_rdata = v.srdata;
      req_write = v.wr;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_strb  = v.strb;
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      chk($sformatf("v%0d_req_ready", idx), {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      chk($sformatf("v%0d_setup", idx), {30'd0, psel, penable}, 32'd2);
      chk($sformatf("v%0d_paddr", idx), paddr, v.addr);
      chk($sformatf("v%0d_pwrite", idx), {31'd0, pwrite}, {31'd0, v.wr});
      chk($sformatf("v%0d_pstrb", idx), {28'd0, pstrb}, {28'd0, (v.wr ? v.strb : 4'h0)});
      a0 = paddr;
      d0 = pwdata;
      stable = 1'b1;
      n = 0;
      @(negedge clk);
      while (psel && penable && n < 50) begin
         n++;
         if (paddr !== a0 || pwdata !== d0) stable = 1'b0;
         @(negedge clk);
      end
      chk($sformatf("v%0d_access_cycles", idx), n, v.exp_acc);
      chk($sformatf("v%0d_payload_stable", idx), {31'd0, stable}, 32'd1);
      chk($sformatf("v%0d_rsp_valid", idx), {30'd0, rsp_valid, psel}, 32'd2);
      chk($sformatf("v%0d_rdata", idx), rsp_rdata, v.exp_rdata);
      chk($sformatf("v%0d_err_to", idx), {30'd0, rsp_err, rsp_timeout},
          {30'd0, v.exp_err, v.exp_to});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_back_idle", idx), {30'd0, rsp_valid, req_ready}, 32'd1);
      slv_hang = 1'b0;
   endtask

   initial begin
      int          n;
      int          acc_t[$];
      logic [31:0] held;
      vec_t        v;

      //         wr    addr          wdata         strb  wt hang  serr  srdata        exp_rdata     err   to    acc
      vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1};
      vecs[1] = '{1'b1, 32'h0000_8004, 32'h1234_5678, 4'hF, 3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,        1'b0, 1'b0, 4};
      vecs[2] = '{1'b0, 32'h0000_4000, 32'h0,        4'h0, 0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b1, 1'b0, 1};
      vecs[3] = '{1'b0, 32'h0000_0ABC, 32'h0,        4'h0, 0, 1'b1, 1'b0, 32'h5555_AAAA, 32'h0,        1'b1, 1'b1, 8};
      vecs[4] = '{1'b0, 32'h0000_0FFC, 32'h0,        4'h0, 1, 1'b0, 1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b0, 2};
      vecs[5] = '{1'b1, 32'h0000_8FF0, 32'hCAFE_0001, 4'h5, 2, 1'b0, 1'b1, 32'h7777_7777, 32'h0,        1'b1, 1'b0, 3};

      rstn = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
      rsp_ready = 1'b0;
      #1;
      chk("rst_ctrl", {27'd0, req_ready, psel, penable, rsp_valid, busy}, 32'h10);
      chk("rst_paddr", paddr, 32'h0);
      chk("rst_rsp", {30'd0, rsp_err, rsp_timeout}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) do_xfer(i, vecs[i]);

      // back-to-back: request held valid, responses taken immediately
      slv_wait = 0; slv_hang = 1'b0; slv_err = 1'b0; slv_rdata = 32'h1111_2222;
      req_write = 1'b0; req_addr = 32'h0000_0020;
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (req_ready) acc_t.push_back(cyc);
         if (acc_t.size() == 2) break;
         @(negedge clk);
      end
      if (acc_t.size() < 2) chk("b2b_accepts", acc_t.size(), 2);
      else                  chk("b2b_gap", acc_t[1] - acc_t[0], 4);
      rsp_ready = 1'b0;
      n = 0;
      while (!rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      held = rsp_rdata;
      chk("b2b_rdata", held, 32'h1111_2222);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("hold%0d_valid_ready", i), {30'd0, rsp_valid, req_ready}, 32'd2);
         chk($sformatf("hold%0d_rdata", i), rsp_rdata, held);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("b2b_idle", {30'd0, rsp_valid, req_ready}, 32'd1);

      // reset in the middle of ACCESS
      slv_hang = 1'b1; slv_rdata = 32'h3333_4444;
      req_addr = 32'h0000_0100; req_write = 1'b1; req_wdata = 32'h9999_8888; req_strb = 4'hF;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_access", {30'd0, psel, penable}, 32'd3);
      rstn = 1'b0;
      #1;
      chk("mid_rst_ctrl", {27'd0, req_ready, psel, penable, rsp_valid, busy}, 32'h10);
      chk("mid_rst_payload", {paddr[15:0], pwdata[7:0], 3'd0, pwrite, pstrb}, 32'h0);
      v = vecs[0];
      slv_hang = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      n = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (rsp_valid || busy) n++;
      end
      chk("post_rst_quiet", n, 0);
      do_xfer(6, v);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
